hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/riscv_hazard_pkg.sv | 41 ++++
 rtl/EX_Forwarding_unit.sv | 28 ++
 rtl/hazard_control_unit.sv | 139 +++++++++++++
 tb/tb_hazard_control_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_hazard_pkg
// Description : Shared types and constants for the hazard control unit:
//               FSM state encoding, forward-select codes and the
//               forward-select priority function.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_hazard_pkg;

   // Front-end controller states
   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   // EX operand mux select codes
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Picks the youngest live producer of a source register; x0 never forwards
   function automatic logic [1:0] fwd_sel(
      input logic       mem_wr,
      input logic [4:0] mem_rd,
      input logic       wb_wr,
      input logic [4:0] wb_rd,
      input logic [4:0] src
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (mem_wr && (mem_rd != 5'd0) && (mem_rd == src)) begin
         sel = FWD_MEM;
      end else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == src)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage : riscv_hazard_pkg
`default_nettype wire

// File: rtl/EX_Forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module      : EX_Forwarding_unit
// Description : Combinational EX operand forward selects. MEM result wins
//               over WB result when both match a source register.
// Revision    : 1.0 - initial release
// ============================================================================
module EX_Forwarding_unit
   import riscv_hazard_pkg::*;
(
   input  logic [4:0] EX_rs1,
   input  logic [4:0] EX_rs2,
   input  logic       MEM_RegWrite,
   input  logic [4:0] MEM_rd,
   input  logic       WB_RegWrite,
   input  logic [4:0] WB_rd,
   output logic [1:0] ForwardA,
   output logic [1:0] ForwardB
);

   // Forward selects for both EX operands, independent of controller state
   always_comb begin
      ForwardA = fwd_sel(MEM_RegWrite, MEM_rd, WB_RegWrite, WB_rd, EX_rs1);
      ForwardB = fwd_sel(MEM_RegWrite, MEM_rd, WB_RegWrite, WB_rd, EX_rs2);
   end

endmodule : EX_Forwarding_unit
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : Pipeline hazard controller: load-use stall, taken-branch
//               flush, multicycle mul/div front-end stall and EX operand
//               forwarding. All controls are combinational from state/inputs.
//               Optional macro HAZARD_PERF_EN adds the Stall_Cycles counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit
   import riscv_hazard_pkg::*;
#(
   parameter int MD_LATENCY = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ID_rs1,
   input  logic [4:0]  ID_rs2,
   input  logic [4:0]  EX_rs1,
   input  logic [4:0]  EX_rs2,
   input  logic [4:0]  EX_rd,
   input  logic        EX_MemRead,
   input  logic        EX_BranchTaken,
   input  logic        EX_MulDiv,
   input  logic        MEM_RegWrite,
   input  logic [4:0]  MEM_rd,
   input  logic        WB_RegWrite,
   input  logic [4:0]  WB_rd,
   output logic        PC_Write,
   output logic        IF_ID_Write,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Flush,
   output logic        EX_Hold,
   output logic        EX_MEM_Flush,
`ifdef HAZARD_PERF_EN
   output logic [31:0] Stall_Cycles,
`endif
   output logic [1:0]  ForwardA,
   output logic [1:0]  ForwardB
);

   // The first stall cycle is spent in RUN, so MD_WAIT lasts MD_LATENCY-1 cycles
   localparam logic [3:0] c_MD_RELOAD = 4'(MD_LATENCY - 2);

   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_md_cnt;
   logic [3:0] w_md_cnt_next;
   logic       w_load_use;

   assign w_load_use = EX_MemRead && (EX_rd != 5'd0) &&
                       ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));

   // State and mul/div countdown register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= RUN;
         r_md_cnt <= 4'd0;
      end else begin
         r_state  <= w_state_next;
         r_md_cnt <= w_md_cnt_next;
      end
   end

   // Next-state and pipeline control decode; branch outranks mul/div and load-use
   always_comb begin
      w_state_next  = r_state;
      w_md_cnt_next = r_md_cnt;
      PC_Write      = 1'b1;
      IF_ID_Write   = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      EX_Hold       = 1'b0;
      EX_MEM_Flush  = 1'b0;
      case (r_state)
         RUN: begin
            if (EX_BranchTaken) begin
               IF_ID_Flush = 1'b1;
               ID_EX_Flush = 1'b1;
            end else if (EX_MulDiv) begin
               PC_Write      = 1'b0;
               IF_ID_Write   = 1'b0;
               EX_Hold       = 1'b1;
               EX_MEM_Flush  = 1'b1;
               w_state_next  = MD_WAIT;
               w_md_cnt_next = c_MD_RELOAD;
            end else if (w_load_use) begin
               PC_Write    = 1'b0;
               IF_ID_Write = 1'b0;
               ID_EX_Flush = 1'b1;
            end
         end
         MD_WAIT: begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            EX_Hold      = 1'b1;
            EX_MEM_Flush = 1'b1;
            if (r_md_cnt == 4'd0) begin
               w_state_next = RUN;
            end else begin
               w_md_cnt_next = r_md_cnt - 4'd1;
            end
         end
         default: begin
            w_state_next  = RUN;
            w_md_cnt_next = 4'd0;
         end
      endcase
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] r_stall_cycles;

   // Saturating count of cycles in which the PC is frozen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= 32'd0;
      end else if (!PC_Write && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign Stall_Cycles = r_stall_cycles;
`endif

   EX_Forwarding_unit u_fwd (
      .EX_rs1       (EX_rs1),
      .EX_rs2       (EX_rs2),
      .MEM_RegWrite (MEM_RegWrite),
      .MEM_rd       (MEM_rd),
      .WB_RegWrite  (WB_RegWrite),
      .WB_rd        (WB_rd),
      .ForwardA     (ForwardA),
      .ForwardB     (ForwardB)
   );

endmodule : hazard_control_unit
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Self-checking bench for hazard_control_unit: vector table,
//               directed multi-cycle sequences and randomized stimulus
//               against a cycle-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

   localparam int LAT = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd;
   logic       EX_MemRead, EX_BranchTaken, EX_MulDiv, MEM_RegWrite, WB_RegWrite;
   logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, EX_MEM_Flush;
   logic [1:0] ForwardA, ForwardB;
`ifdef HAZARD_PERF_EN
   logic [31:0] Stall_Cycles;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_control_unit #(.MD_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
      .EX_MemRead(EX_MemRead), .EX_BranchTaken(EX_BranchTaken), .EX_MulDiv(EX_MulDiv),
      .MEM_RegWrite(MEM_RegWrite), .MEM_rd(MEM_rd),
      .WB_RegWrite(WB_RegWrite), .WB_rd(WB_rd),
      .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Flush(ID_EX_Flush), .EX_Hold(EX_Hold), .EX_MEM_Flush(EX_MEM_Flush),
`ifdef HAZARD_PERF_EN
      .Stall_Cycles(Stall_Cycles),
`endif
      .ForwardA(ForwardA), .ForwardB(ForwardB)
   );

   // Output bundle: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, EX_MEM_Flush, FwdA, FwdB}
   function automatic logic [9:0] outs();
      return {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, EX_MEM_Flush,
              ForwardA, ForwardB};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      string      name;
      logic [4:0] id1, id2, e1, e2, erd;
      logic       mr, br, mw;
      logic [4:0] mrd;
      logic       ww;
      logic [4:0] wrd;
      logic [9:0] exp;
   } vec_t;

   function automatic vec_t mk(input string n, input logic [4:0] id1, id2, e1, e2, erd,
                               input logic mr, br, mw, input logic [4:0] mrd,
                               input logic ww, input logic [4:0] wrd, input logic [9:0] exp);
      vec_t v;
      v.name = n; v.id1 = id1; v.id2 = id2; v.e1 = e1; v.e2 = e2; v.erd = erd;
      v.mr = mr; v.br = br; v.mw = mw; v.mrd = mrd; v.ww = ww; v.wrd = wrd; v.exp = exp;
      return v;
   endfunction

   task automatic clear_inputs();
      {ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd} = '0;
      {EX_MemRead, EX_BranchTaken, EX_MulDiv, MEM_RegWrite, WB_RegWrite} = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   vec_t vt[13];

   initial begin
      int          md_left;
      logic [9:0]  exp;
      logic [1:0]  fa, fb;
      logic [31:0] perf_before, perf_model;
      logic        lu;

      perf_before = '0;
      perf_model  = '0;

      vt[0]  = mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1100000000);
      vt[1]  = mk("lu_rs2",     3, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 10'b0001000000);
      vt[2]  = mk("lu_rs1",     9, 2, 0, 0, 9, 1, 0, 0, 0, 0, 0, 10'b0001000000);
      vt[3]  = mk("lu_rd0",     0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10'b1100000000);
      vt[4]  = mk("lu_nomatch", 6, 7, 0, 0, 5, 1, 0, 0, 0, 0, 0, 10'b1100000000);
      vt[5]  = mk("no_memread", 5, 5, 0, 0, 5, 0, 0, 0, 0, 0, 0, 10'b1100000000);
      vt[6]  = mk("br_over_lu", 3, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 10'b1111000000);
      vt[7]  = mk("fwdA_mem",   0, 0, 7, 0, 0, 0, 0, 1, 7, 1, 7, 10'b1100001000);
      vt[8]  = mk("fwdA_wb",    0, 0, 7, 0, 0, 0, 0, 1, 0, 1, 7, 10'b1100000100);
      vt[9]  = mk("fwdA_rs0",   0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 10'b1100000000);
      vt[10] = mk("fwd_norw",   0, 0, 7, 7, 0, 0, 0, 0, 7, 0, 7, 10'b1100000000);
      vt[11] = mk("fwd_mix",    0, 0, 3, 4, 0, 0, 0, 1, 3, 1, 4, 10'b1100001001);
      vt[12] = mk("fwdB_mem",   0, 0, 0, 8, 0, 0, 0, 1, 8, 1, 8, 10'b1100000010);

      do_reset();

      // ---------------- reset state ----------------
      @(negedge clk);
      chk("reset_outs", 32'(outs()), 32'(10'b1100000000));
`ifdef HAZARD_PERF_EN
      chk("reset_perf", Stall_Cycles, 32'd0);
`endif

      // ---------------- vector table (RUN state, no mul/div) ----------------
      foreach (vt[i]) begin
         @(posedge clk); #1;
         ID_rs1 = vt[i].id1; ID_rs2 = vt[i].id2; EX_rs1 = vt[i].e1; EX_rs2 = vt[i].e2;
         EX_rd = vt[i].erd; EX_MemRead = vt[i].mr; EX_BranchTaken = vt[i].br; EX_MulDiv = 1'b0;
         MEM_RegWrite = vt[i].mw; MEM_rd = vt[i].mrd; WB_RegWrite = vt[i].ww; WB_rd = vt[i].wrd;
         @(negedge clk);
         chk(vt[i].name, 32'(outs()), 32'(vt[i].exp));
      end

      // ---------------- load-use then load moves on ----------------
      @(posedge clk); #1 clear_inputs();
      EX_MemRead = 1; EX_rd = 5; ID_rs2 = 5;
      @(negedge clk); chk("lu_seq_stall", 32'(outs()), 32'(10'b0001000000));
      @(posedge clk); #1 clear_inputs();
      @(negedge clk); chk("lu_seq_after", 32'(outs()), 32'(10'b1100000000));

      // ---------------- mul/div pulse: LAT stall cycles ----------------
`ifdef HAZARD_PERF_EN
      perf_before = Stall_Cycles;
`endif
      @(posedge clk); #1 EX_MulDiv = 1;
      for (int c = 0; c < LAT; c++) begin
         @(negedge clk);
         chk($sformatf("md_stall_%0d", c), 32'(outs()), 32'(10'b0000110000));
         @(posedge clk); #1 EX_MulDiv = 0;
      end
      @(negedge clk); chk("md_done", 32'(outs()), 32'(10'b1100000000));
`ifdef HAZARD_PERF_EN
      chk("md_perf_delta", Stall_Cycles - perf_before, 32'd4);
`endif

      // ---------------- reset in 2nd MD_WAIT cycle ----------------
      @(posedge clk); #1 EX_MulDiv = 1;
      @(posedge clk); #1 EX_MulDiv = 0;
      @(posedge clk); #1;
      @(negedge clk); chk("md_wait2_stall", 32'(outs()), 32'(10'b0000110000));
      #1 rst_n = 1'b0;
      #1 chk("async_reset_run", 32'(outs()), 32'(10'b1100000000));
`ifdef HAZARD_PERF_EN
      chk("async_reset_perf", Stall_Cycles, 32'd0);
`endif
      @(posedge clk); #1 rst_n = 1'b1;
      // Counter restarted: a new pulse must stall exactly LAT cycles
      @(posedge clk); #1 EX_MulDiv = 1;
      for (int c = 0; c < LAT; c++) begin
         @(negedge clk);
         chk($sformatf("post_rst_stall_%0d", c), 32'(PC_Write), 32'd0);
         @(posedge clk); #1 EX_MulDiv = 0;
      end
      @(negedge clk); chk("post_rst_done", 32'(PC_Write), 32'd1);

      // ---------------- mul/div with branch: branch wins ----------------
      @(posedge clk); #1 clear_inputs();
      EX_MulDiv = 1; EX_BranchTaken = 1;
      @(negedge clk); chk("md_br_flush", 32'(outs()), 32'(10'b1111000000));
      @(posedge clk); #1 clear_inputs();
      @(negedge clk); chk("md_br_next_run", 32'(outs()), 32'(10'b1100000000));

      // ---------------- randomized run vs reference model ----------------
      do_reset();
      md_left    = 0;   // remaining stall cycles owed to an in-flight mul/div
      perf_model = '0;
      for (int n = 0; n < 2000; n++) begin
         @(posedge clk); #1;
         ID_rs1 = 5'($urandom_range(0, 3)); ID_rs2 = 5'($urandom_range(0, 3));
         EX_rs1 = 5'($urandom_range(0, 3)); EX_rs2 = 5'($urandom_range(0, 3));
         EX_rd  = 5'($urandom_range(0, 3));
         MEM_rd = 5'($urandom_range(0, 3)); WB_rd = 5'($urandom_range(0, 3));
         MEM_RegWrite   = 1'($urandom_range(0, 1));
         WB_RegWrite    = 1'($urandom_range(0, 1));
         EX_BranchTaken = ($urandom_range(0, 5) == 0);
         EX_MulDiv      = ($urandom_range(0, 7) == 0);
         EX_MemRead     = !EX_MulDiv && ($urandom_range(0, 2) == 0);

         fa = 2'b00;
         if (MEM_RegWrite && MEM_rd != 0 && MEM_rd == EX_rs1) fa = 2'b10;
         else if (WB_RegWrite && WB_rd != 0 && WB_rd == EX_rs1) fa = 2'b01;
         fb = 2'b00;
         if (MEM_RegWrite && MEM_rd != 0 && MEM_rd == EX_rs2) fb = 2'b10;
         else if (WB_RegWrite && WB_rd != 0 && WB_rd == EX_rs2) fb = 2'b01;
         lu = EX_MemRead && EX_rd != 0 && (EX_rd == ID_rs1 || EX_rd == ID_rs2);

         if (md_left > 0) begin
            exp = {6'b000011, fa, fb};
            md_left--;
         end else if (EX_BranchTaken) begin
            exp = {6'b111100, fa, fb};
         end else if (EX_MulDiv) begin
            exp = {6'b000011, fa, fb};
            md_left = LAT - 1;
         end else if (lu) begin
            exp = {6'b000100, fa, fb};
         end else begin
            exp = {6'b110000, fa, fb};
         end

         @(negedge clk);
         chk($sformatf("rand_%0d", n), 32'(outs()), 32'(exp));
`ifdef HAZARD_PERF_EN
         chk($sformatf("rand_perf_%0d", n), Stall_Cycles, perf_model);
`endif
         if (!exp[9]) perf_model++;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_hazard_control_unit
`default_nettype wire
